// File: rtl/rs_dsp_multacc_seq.sv
// rs_dsp_multacc_seq
//   Sequences one dot-product job through a DSP38 configured as a multiply-
//   accumulate with input and output registers. A job (length + arithmetic
//   configuration) is accepted in IDLE. Operand pairs are then streamed into
//   the DSP through a valid/ready handshake. The block waits out the DSP
//   pipeline and presents the 38-bit sum on a valid/ready result port.
//
// Ports
//   clk, lreset            clock, synchronous active-high reset
//   start, len, cfg_*      job request (start honoured only when idle)
//   busy                   high whenever not idle
//   s_valid/s_ready/s_a/s_b  operand stream (s_ready high only while feeding)
//   dsp_*                  DSP operand and control pins (this block is sole driver)
//   dsp_z                  DSP accumulator output
//   m_valid/m_ready/m_z    result port
module rs_dsp_multacc_seq #(
  parameter int LEN_W = 8,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             lreset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             cfg_unsigned_a,
  input  logic             cfg_unsigned_b,
  input  logic             cfg_round,
  input  logic             cfg_saturate,
  input  logic             cfg_subtract,
  input  logic [5:0]       cfg_shift,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [19:0]      s_a,
  input  logic [17:0]      s_b,
  output logic [19:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [2:0]       dsp_feedback,
  output logic             dsp_load_acc,
  output logic             dsp_unsigned_a,
  output logic             dsp_unsigned_b,
  output logic             dsp_round,
  output logic             dsp_saturate,
  output logic             dsp_subtract,
  output logic [5:0]       dsp_shift_right,
  input  logic [37:0]      dsp_z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [37:0]      m_z
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [37:0]      m_z_q, m_z_d;
  logic             ua_q, ua_d, ub_q, ub_d, rnd_q, rnd_d, sat_q, sat_d, sub_q, sub_d;
  logic [5:0]       shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (lreset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      m_z_q   <= '0;
      ua_q    <= 1'b0;
      ub_q    <= 1'b0;
      rnd_q   <= 1'b0;
      sat_q   <= 1'b0;
      sub_q   <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      m_z_q   <= m_z_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      rnd_q   <= rnd_d;
      sat_q   <= sat_d;
      sub_q   <= sub_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    m_z_d        = m_z_q;
    ua_d         = ua_q;
    ub_d         = ub_q;
    rnd_d        = rnd_q;
    sat_d        = sat_q;
    sub_d        = sub_q;
    shift_d      = shift_q;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    dsp_a        = '0;
    dsp_b        = '0;
    dsp_load_acc = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            rem_d   = len;
            first_d = 1'b1;
            ua_d    = cfg_unsigned_a;
            ub_d    = cfg_unsigned_b;
            rnd_d   = cfg_round;
            sat_d   = cfg_saturate;
            sub_d   = cfg_subtract;
            shift_d = cfg_shift;
            state_d = FEED;
          end else begin
            m_z_d   = '0;
            state_d = HOLD;
          end
        end
      end
      FEED: begin
        s_ready = 1'b1;
        // Until the first pair is taken, keep reloading the accumulator with
        // a zero product so the job never inherits a previous sum. After
        // that, load_acc=1 accumulates real pairs and holds across bubbles.
        dsp_load_acc = ~first_q;
        if (s_valid) begin
          dsp_a   = s_a;
          dsp_b   = s_b;
          rem_d   = rem_q - LEN_W'(1);
          first_d = 1'b0;
          if (rem_q == LEN_W'(1)) begin
            cnt_d   = CNT_W'(LAT);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        dsp_load_acc = 1'b1;
        // Counter reaches 0 one edge after the last product lands in dsp_z.
        if (cnt_q == '0) begin
          m_z_d   = dsp_z;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign m_z             = m_z_q;
  assign dsp_feedback    = 3'b000;
  assign dsp_unsigned_a  = ua_q;
  assign dsp_unsigned_b  = ub_q;
  assign dsp_round       = rnd_q;
  assign dsp_saturate    = sat_q;
  assign dsp_subtract    = sub_q;
  assign dsp_shift_right = shift_q;

endmodule

// File: tb/tb_rs_dsp_multacc_seq.sv
// Testbench for rs_dsp_multacc_seq. A small signed MAC model with input and
// output registers stands in for the DSP. Expected sums are plain dot
// products of the job operands. Inputs are driven and outputs sampled 1 ns
// after the rising edge.
module tb_rs_dsp_multacc_seq;
  localparam int LEN_W = 8;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             lreset, start, s_valid, m_ready;
  logic [LEN_W-1:0] len;
  logic             cfg_unsigned_a, cfg_unsigned_b, cfg_round, cfg_saturate, cfg_subtract;
  logic [5:0]       cfg_shift;
  logic             busy, s_ready, m_valid, dsp_load_acc;
  logic [19:0]      s_a, dsp_a;
  logic [17:0]      s_b, dsp_b;
  logic [2:0]       dsp_feedback;
  logic             dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract;
  logic [5:0]       dsp_shift_right;
  logic [37:0]      dsp_z, m_z;

  rs_dsp_multacc_seq #(.LEN_W(LEN_W), .LAT(LAT)) dut (
    .clk(clk), .lreset(lreset), .start(start), .len(len),
    .cfg_unsigned_a(cfg_unsigned_a), .cfg_unsigned_b(cfg_unsigned_b),
    .cfg_round(cfg_round), .cfg_saturate(cfg_saturate), .cfg_subtract(cfg_subtract),
    .cfg_shift(cfg_shift), .busy(busy), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_feedback(dsp_feedback),
    .dsp_load_acc(dsp_load_acc), .dsp_unsigned_a(dsp_unsigned_a),
    .dsp_unsigned_b(dsp_unsigned_b), .dsp_round(dsp_round), .dsp_saturate(dsp_saturate),
    .dsp_subtract(dsp_subtract), .dsp_shift_right(dsp_shift_right), .dsp_z(dsp_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z)
  );

  // DSP stand-in: registered inputs, registered accumulator (2 edges to Z).
  logic [19:0] ra = '0;
  logic [17:0] rb = '0;
  logic        rla = 1'b0;
  logic [37:0] acc = '0;
  logic signed [37:0] prod;
  assign prod  = $signed({{18{ra[19]}}, ra}) * $signed({{20{rb[17]}}, rb});
  assign dsp_z = acc;
  always @(posedge clk) begin
    ra  <= dsp_a;
    rb  <= dsp_b;
    rla <= dsp_load_acc;
    acc <= rla ? (acc + prod) : prod;
  end

  int tests_run = 0;
  int tests_failed = 0;

  int ja[0:31];
  int jb[0:31];

  int          obs_edges, obs_hs, obs_bubble_err, obs_hs_err, obs_cfg_err;
  logic [31:0] obs_la;
  logic        obs_sready_seen, obs_timeout;

  function automatic logic [37:0] ref_dot(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++) s += longint'(ja[k]) * longint'(jb[k]);
    return s[37:0];
  endfunction

  // Edges from the start edge until m_valid is set: every FEED cycle
  // (valid or gap) until the n-th pair, then LAT + 1 drain edges.
  function automatic int ref_edges(input int n, input logic [31:0] gaps);
    int f = 0;
    int k = 0;
    while (k < n) begin
      if (f < 32 && gaps[f]) ; else k++;
      f++;
    end
    return f + LAT + 1;
  endfunction

  function automatic logic [31:0] ref_la(input int n);
    logic [31:0] m = '0;
    for (int k = 1; k < n; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Drives one job up to HOLD and records observations; checks are done by
  // the calling test.
  task automatic run_job(input int n, input logic [31:0] gap_mask, input bit scramble);
    logic [10:0] snap;
    int fcyc = 0;
    snap  = {cfg_unsigned_a, cfg_unsigned_b, cfg_round, cfg_saturate, cfg_subtract, cfg_shift};
    start = 1'b1;
    len   = LEN_W'(n);
    s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    obs_edges = 0; obs_hs = 0; obs_bubble_err = 0; obs_hs_err = 0; obs_cfg_err = 0;
    obs_la = '0; obs_sready_seen = 1'b0;
    while (m_valid !== 1'b1 && obs_edges < 300) begin
      if (scramble)
        {cfg_unsigned_a, cfg_unsigned_b, cfg_round, cfg_saturate, cfg_subtract, cfg_shift} = 11'($urandom);
      if (s_ready === 1'b1) begin
        obs_sready_seen = 1'b1;
        if (obs_hs < n && !(fcyc < 32 && gap_mask[fcyc])) begin
          s_valid = 1'b1;
          s_a = 20'(ja[obs_hs]);
          s_b = 18'(jb[obs_hs]);
        end else begin
          s_valid = 1'b0;
          s_a = 20'($urandom);
          s_b = 18'($urandom);
        end
        fcyc++;
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_a = 20'($urandom);
        s_b = 18'($urandom);
      end
      #1;
      if (s_valid && s_ready) begin
        if (dsp_a !== s_a || dsp_b !== s_b) obs_hs_err++;
        obs_la[obs_hs] = dsp_load_acc;
        obs_hs++;
      end else if (busy) begin
        if (dsp_a !== '0 || dsp_b !== '0 || dsp_load_acc !== (obs_hs != 0)) obs_bubble_err++;
      end
      if (n != 0 && {dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract,
                     dsp_shift_right} !== snap) obs_cfg_err++;
      @(posedge clk); #1;
      obs_edges++;
    end
    s_valid = 1'b0;
    obs_timeout = (m_valid !== 1'b1);
    $display("[TB] job len=%0d edges=%0d handshakes=%0d m_z=%0d", n, obs_edges, obs_hs, $signed(m_z));
  endtask

  task automatic accept_result(input int delay);
    m_ready = 1'b0;
    repeat (delay) @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    lreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, s_ready, m_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/s_ready/m_valid got %b want 000", {busy, s_ready, m_valid});
    end
    tests_run++;
    if (m_z !== '0) begin
      tests_failed++;
      $display("FAIL reset_m_z: got %0h want 0", m_z);
    end
    tests_run++;
    if ({dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract, dsp_shift_right} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_cfg: got %0h want 0",
               {dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract, dsp_shift_right});
    end
    tests_run++;
    if ({dsp_a, dsp_b, dsp_load_acc, dsp_feedback} !== 42'd0) begin
      tests_failed++;
      $display("FAIL reset_dsp_drive: a=%0h b=%0h la=%b fb=%b want all 0", dsp_a, dsp_b, dsp_load_acc, dsp_feedback);
    end
    lreset = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) begin ja[k] = k + 1; jb[k] = k + 5; end
    run_job(4, 32'd0, 1'b0);
    tests_run++;
    if (obs_timeout || m_z !== 38'd70) begin
      tests_failed++;
      $display("FAIL basic_sum: got %0d want 70 (timeout=%b)", $signed(m_z), obs_timeout);
    end
    tests_run++;
    if (obs_edges != 7) begin
      tests_failed++;
      $display("FAIL basic_latency: m_valid after %0d edges want 7", obs_edges);
    end
    tests_run++;
    if (obs_la[3:0] !== 4'b1110 || obs_hs_err != 0) begin
      tests_failed++;
      $display("FAIL basic_load_acc: pattern %b want 1110 (operand errs %0d)", obs_la[3:0], obs_hs_err);
    end
    tests_run++;
    if (obs_bubble_err != 0) begin
      tests_failed++;
      $display("FAIL basic_idle_drive: %0d bad idle cycles want 0", obs_bubble_err);
    end
    accept_result(0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release: busy got %b want 0", busy);
    end
  endtask

  task automatic test_bubbles();
    for (int k = 0; k < 4; k++) begin ja[k] = k + 1; jb[k] = k + 5; end
    run_job(4, 32'b110, 1'b0);
    tests_run++;
    if (obs_timeout || m_z !== 38'd70) begin
      tests_failed++;
      $display("FAIL bubble_sum: got %0d want 70", $signed(m_z));
    end
    tests_run++;
    if (obs_edges != 9) begin
      tests_failed++;
      $display("FAIL bubble_latency: m_valid after %0d edges want 9", obs_edges);
    end
    tests_run++;
    if (obs_bubble_err != 0 || obs_la[3:0] !== 4'b1110) begin
      tests_failed++;
      $display("FAIL bubble_drive: bad bubbles %0d, pattern %b want 0 and 1110", obs_bubble_err, obs_la[3:0]);
    end
    accept_result(1);
  endtask

  task automatic test_len0();
    run_job(0, 32'd0, 1'b0);
    tests_run++;
    if (obs_timeout || obs_edges != 0 || m_z !== '0) begin
      tests_failed++;
      $display("FAIL len0_result: edges %0d m_z %0h want 0 and 0", obs_edges, m_z);
    end
    tests_run++;
    if (obs_sready_seen !== 1'b0 || s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL len0_no_ready: s_ready seen %b want 0", obs_sready_seen);
    end
    accept_result(0);
  endtask

  task automatic test_back_to_back();
    logic [37:0] z0;
    int bad = 0;
    ja[0] = -3; jb[0] = 100;
    run_job(1, 32'd0, 1'b0);
    tests_run++;
    if (obs_timeout || m_z !== 38'(-300)) begin
      tests_failed++;
      $display("FAIL b2b_first: got %0d want -300", $signed(m_z));
    end
    z0 = m_z;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; len = LEN_W'(1 + $urandom_range(0, 3)); s_valid = 1'b1;
      @(posedge clk); #1;
      if (m_z !== z0 || m_valid !== 1'b1 || s_ready !== 1'b0) bad++;
    end
    start = 1'b0; s_valid = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: %0d unstable hold cycles want 0", bad);
    end
    accept_result(0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_start_ignored: busy got %b want 0", busy);
    end
    ja[0] = 2; jb[0] = 2;
    run_job(1, 32'd0, 1'b0);
    tests_run++;
    if (obs_timeout || m_z !== 38'd4) begin
      tests_failed++;
      $display("FAIL b2b_second: got %0d want 4", $signed(m_z));
    end
    accept_result(0);
  endtask

  task automatic test_reset_mid();
    cfg_round = 1'b1; cfg_shift = 6'd5;
    start = 1'b1; len = LEN_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_a = 20'(k + 1); s_b = 18'(k + 5);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; lreset = 1'b1;
    @(posedge clk); #1;
    lreset = 1'b0;
    tests_run++;
    if ({busy, s_ready, m_valid} !== 3'b000 || m_z !== '0) begin
      tests_failed++;
      $display("FAIL midreset_state: flags %b m_z %0h want 000 and 0", {busy, s_ready, m_valid}, m_z);
    end
    tests_run++;
    if (dsp_round !== 1'b0 || dsp_shift_right !== 6'd0) begin
      tests_failed++;
      $display("FAIL midreset_cfg: round %b shift %0d want 0 0", dsp_round, dsp_shift_right);
    end
    cfg_round = 1'b0; cfg_shift = 6'd0;
    ja[0] = 7; jb[0] = 7;
    run_job(1, 32'd0, 1'b0);
    tests_run++;
    if (obs_timeout || m_z !== 38'd49) begin
      tests_failed++;
      $display("FAIL midreset_next: got %0d want 49", $signed(m_z));
    end
    accept_result(0);
  endtask

  task automatic test_cfg_latch();
    cfg_unsigned_a = 1'b1; cfg_shift = 6'd3; cfg_subtract = 1'b1;
    for (int k = 0; k < 3; k++) begin ja[k] = k; jb[k] = 3 - k; end
    run_job(3, 32'b10, 1'b1);
    tests_run++;
    if (obs_timeout || obs_cfg_err != 0) begin
      tests_failed++;
      $display("FAIL cfg_stable: %0d cycles with changed config want 0", obs_cfg_err);
    end
    cfg_unsigned_a = 1'b0; cfg_shift = 6'd9; cfg_subtract = 1'b0;
    accept_result(2);
    tests_run++;
    if ({dsp_unsigned_a, dsp_shift_right, dsp_subtract} !== {1'b1, 6'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL cfg_idle_hold: ua/shift/sub got %b/%0d/%b want 1/3/1",
               dsp_unsigned_a, dsp_shift_right, dsp_subtract);
    end
    ja[0] = 1; jb[0] = 1;
    run_job(1, 32'd0, 1'b0);
    tests_run++;
    if ({dsp_unsigned_a, dsp_shift_right, dsp_subtract} !== {1'b0, 6'd9, 1'b0} || obs_cfg_err != 0) begin
      tests_failed++;
      $display("FAIL cfg_reload: ua/shift/sub got %b/%0d/%b want 0/9/0",
               dsp_unsigned_a, dsp_shift_right, dsp_subtract);
    end
    accept_result(0);
    cfg_shift = 6'd0;
  endtask

  task automatic test_random();
    int n;
    logic [31:0] gaps;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 12);
      gaps = 32'($urandom_range(0, 4095));
      for (int k = 0; k < n; k++) begin
        ja[k] = int'($urandom_range(0, 1048575)) - 524288;
        jb[k] = int'($urandom_range(0, 262143)) - 131072;
      end
      run_job(n, gaps, 1'b0);
      tests_run++;
      if (obs_timeout || m_z !== ref_dot(n)) begin
        tests_failed++;
        $display("FAIL rand_sum[%0d]: got %0h want %0h", j, m_z, ref_dot(n));
      end
      tests_run++;
      if (obs_edges != ref_edges(n, gaps) || obs_la !== ref_la(n) || obs_bubble_err != 0 || obs_hs_err != 0) begin
        tests_failed++;
        $display("FAIL rand_timing[%0d]: edges %0d want %0d, la %0h want %0h, bubble errs %0d, operand errs %0d",
                 j, obs_edges, ref_edges(n, gaps), obs_la, ref_la(n), obs_bubble_err, obs_hs_err);
      end
      accept_result($urandom_range(0, 3));
      if (obs_timeout) begin
        lreset = 1'b1;
        @(posedge clk); #1;
        lreset = 1'b0;
      end
    end
  endtask

  initial begin
    lreset = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0; m_ready = 1'b0;
    s_a = '0; s_b = '0;
    cfg_unsigned_a = 1'b0; cfg_unsigned_b = 1'b0; cfg_round = 1'b0;
    cfg_saturate = 1'b0; cfg_subtract = 1'b0; cfg_shift = '0;
    test_reset();
    test_basic();
    test_bubbles();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    test_cfg_latch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rs_dsp_multacc_seq.md
# rs_dsp_multacc_seq

Job sequencer for one DSP38 in MULTIPLY_ACCUMULATE mode with input and output registers enabled. It takes a dot-product job (length plus arithmetic configuration) and streams operand pairs into the DSP through a valid/ready handshake. It drives the DSP accumulate controls so that every job starts from a fresh accumulator, then waits out the pipeline latency and returns the 38-bit sum on a valid/ready result port. It sits between a fabric operand source and the DSP instance; it is the only driver of the DSP control pins.

## Interface
- LEN_W, 8: width of job length; max job length 2^LEN_W-1.
- LAT, 2: clock edges from an operand handshake edge until dsp_z reflects that operand.

- clk  in  1  single clock, rising edge.
- lreset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  element count of the job.
- cfg_unsigned_a, cfg_unsigned_b, cfg_round, cfg_saturate, cfg_subtract  in  1 each  arithmetic config; latched at start.
- cfg_shift  in  6  right shift amount; latched at start.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  high only in FEED.
- s_a  in  20  operand A.
- s_b  in  18  operand B.
- dsp_a  out  20  to DSP A.
- dsp_b  out  18  to DSP B.
- dsp_feedback  out  3  constant 3'b000.
- dsp_load_acc  out  1  to DSP LOAD_ACC.
- dsp_unsigned_a, dsp_unsigned_b, dsp_round, dsp_saturate, dsp_subtract  out  1 each  latched config.
- dsp_shift_right  out  6  latched cfg_shift.
- dsp_z  in  38  DSP Z.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_z  out  38  captured result.

## Operation
- States:
  - IDLE: waits for a job.
  - FEED: streams operands.
  - DRAIN: waits out DSP latency.
  - HOLD: presents the result.
- IDLE:
  - start=1 with len≠0 latches len into the remaining count `rem`, latches all cfg_* registers, clears the `first` flag to 1, then goes to FEED.
  - start=1 with len=0 loads m_z=0 and goes to HOLD.
- FEED:
  - s_ready=1.
  - A handshake (s_valid&s_ready) drives dsp_a=s_a and dsp_b=s_b combinationally.
  - dsp_load_acc=0 on the first handshake of the job, which loads the accumulator with the product. It is 1 on every later handshake, which accumulates.
  - Each handshake decrements `rem` and clears `first`.
  - On a handshake with rem=1, a drain counter is loaded with LAT and the block goes to DRAIN.
- Bubbles:
  - Any cycle in FEED/DRAIN without a handshake drives dsp_a=0, dsp_b=0, dsp_load_acc=1, so the accumulator is unchanged.
  - Exception: while `first`=1 and no handshake has occurred, dsp_load_acc=0 with zero operands. This keeps clearing the accumulator.
- DRAIN:
  - s_ready=0.
  - The counter decrements each edge.
  - At the edge where the counter is 0, dsp_z is captured into m_z and the block goes to HOLD.
- HOLD:
  - m_valid=1 and m_z is stable.
  - On m_valid&m_ready the block goes to IDLE.
- IDLE/HOLD DSP drive: dsp_a=0, dsp_b=0, dsp_load_acc=0.
- Configuration outputs:
  - dsp_* config outputs are driven from the latched registers and are constant for a whole job.
  - They change only on a start acceptance.
- Ignored events: start while busy; s_valid outside FEED; m_ready outside HOLD.
- Arithmetic: no width conversion in this block. m_z is dsp_z bit-exact; signedness, shift, round, saturate and subtract are applied inside the DSP.

## Timing
- Reset values (lreset=1 at an edge):
  - state=IDLE, busy=0, s_ready=0, m_valid=0, m_z=0.
  - rem=0, drain counter=0, first=1.
  - All latched cfg = 0, so dsp_shift_right=0 and dsp config bits 0.
  - Reset mid-job abandons the job with no result. The next job's first element reloads the accumulator, so no stale sum leaks.
- start accepted at edge S: busy=1 and s_ready=1 from S+1.
- Operand throughput: one pair per cycle when s_valid is held high.
- Last handshake at edge E: s_ready=0 from E+1; dsp_z is captured at edge E+LAT+1; m_valid=1 from E+LAT+1.
- Example: len=4, no bubbles, start at S: handshakes at S+1..S+4, m_valid from S+4+LAT+1 (S+7 for LAT=2).
- Result acceptance: m_valid&m_ready at edge R gives busy=0 from R+1. The earliest next start acceptance is R+1.
- len=0: start at S gives m_valid=1 and m_z=0 from S+1.

## Test plan
- Signed job, len=4, a={1,2,3,4}, b={5,6,7,8}, s_valid held high -> m_z=70. dsp_load_acc pattern 0,1,1,1 on the handshakes. m_valid at S+7 (LAT=2).
- Same job with s_valid low on cycles 2 and 3 of FEED -> m_z=70. Zero operands with load_acc=1 on the bubbles. m_valid delayed by exactly 2 cycles.
- Back-to-back jobs:
  - First job a={-3}, b={100} -> m_z=-300.
  - m_ready held low 5 cycles: m_z stable and start ignored while held.
  - Second job a={2}, b={2} -> m_z=4, proving no carry-over.
- len=0 -> m_valid one cycle after start, m_z=0, no s_ready pulse.
- Reset mid-job: lreset asserted after 2 of 4 handshakes -> all outputs at reset values next cycle. A following len=1 job with a=7, b=7 -> m_z=49.
- Config latch:
  - start with cfg_unsigned_a=1, cfg_shift=6'd3, cfg_subtract=1.
  - Change the cfg_* inputs mid-job -> dsp_* outputs stay 1/3/1 until the next start acceptance.
